// File: rtl/fetch_pair_queue_if.sv
// Handshake bundle between fetch, the pair queue and decode.
// The slave modport is the queue's view; master is the fetch/decode side.
interface fetch_pair_queue_if #(
    parameter int IW = 32,
    parameter int AW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr_1;
    logic [IW-1:0] in_instr_2;
    logic [AW-1:0] in_pc_1;
    logic [AW-1:0] in_pc_2;

    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr_1;
    logic [IW-1:0] out_instr_2;
    logic [AW-1:0] out_pc_1;
    logic [AW-1:0] out_pc_2;

    modport master (
        output in_valid, in_instr_1, in_instr_2, in_pc_1, in_pc_2, out_ready,
        input  in_ready, out_valid, out_instr_1, out_instr_2, out_pc_1, out_pc_2
    );

    modport slave (
        input  in_valid, in_instr_1, in_instr_2, in_pc_1, in_pc_2, out_ready,
        output in_ready, out_valid, out_instr_1, out_instr_2, out_pc_1, out_pc_2
    );
endinterface

// File: rtl/fetch_pair_queue.sv
// FIFO of fetched instruction pairs between fetch and dual-issue decode.
// Occupancy is tracked by count; a flush empties the queue in one cycle.
module fetch_pair_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    fetch_pair_queue_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [IW-1:0] instr_1;
        logic [IW-1:0] instr_2;
        logic [AW-1:0] pc_1;
        logic [AW-1:0] pc_2;
    } pair_t;

    pair_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    pair_t          in_pair;
    pair_t          head;

    assign bus.in_ready  = (count != FULL);
    assign bus.out_valid = (count != '0);

    // Flush wins over both transfers, so neither pointer moves on its own
    assign push = bus.in_valid  & bus.in_ready  & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    assign in_pair = '{instr_1: bus.in_instr_1, instr_2: bus.in_instr_2,
                       pc_1: bus.in_pc_1, pc_2: bus.in_pc_2};

    // Stale entries stay in storage after a pop or flush, so mask the head when empty
    assign head = bus.out_valid ? mem[rd_ptr] : '0;

    assign bus.out_instr_1 = head.instr_1;
    assign bus.out_instr_2 = head.instr_2;
    assign bus.out_pc_1    = head.pc_1;
    assign bus.out_pc_2    = head.pc_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_pair;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pair_queue.sv
// Self-checking bench for fetch_pair_queue: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_fetch_pair_queue;
    localparam int DEPTH = 4;
    localparam int IW    = 32;
    localparam int AW    = 32;

    typedef struct packed {
        logic [IW-1:0] instr_1;
        logic [IW-1:0] instr_2;
        logic [AW-1:0] pc_1;
        logic [AW-1:0] pc_2;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [2:0] count;

    fetch_pair_queue_if #(.IW(IW), .AW(AW)) bus ();

    fetch_pair_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    pair_t model[$];
    int    checks = 0;
    int    fails  = 0;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs follow purely from the model's occupancy and head entry
    task automatic checkAll(input string tag);
        pair_t exp_head;
        exp_head = (model.size() != 0) ? model[0] : '0;
        checkOutput({tag, ".count"},     128'(count),           128'(model.size()));
        checkOutput({tag, ".in_ready"},  128'(bus.in_ready),    128'(model.size() != DEPTH));
        checkOutput({tag, ".out_valid"}, 128'(bus.out_valid),   128'(model.size() != 0));
        checkOutput({tag, ".instr_1"},   128'(bus.out_instr_1), 128'(exp_head.instr_1));
        checkOutput({tag, ".instr_2"},   128'(bus.out_instr_2), 128'(exp_head.instr_2));
        checkOutput({tag, ".pc_1"},      128'(bus.out_pc_1),    128'(exp_head.pc_1));
        checkOutput({tag, ".pc_2"},      128'(bus.out_pc_2),    128'(exp_head.pc_2));
    endtask

    function automatic pair_t randPair();
        pair_t p;
        p.instr_1 = $urandom;
        p.instr_2 = $urandom;
        p.pc_1    = $urandom & 32'hFFFF_FFF8;
        p.pc_2    = p.pc_1 + 32'd4;
        return p;
    endfunction

    // Drive one cycle of inputs, update the model at the edge, then check 1 time unit later
    task automatic applyStimulus(input logic v, input logic rdy, input logic fl, input pair_t p, input string tag);
        bit do_push;
        bit do_pop;
        bus.in_valid   = v;
        bus.out_ready  = rdy;
        flush          = fl;
        bus.in_instr_1 = p.instr_1;
        bus.in_instr_2 = p.instr_2;
        bus.in_pc_1    = p.pc_1;
        bus.in_pc_2    = p.pc_2;
        do_push = v && (model.size() < DEPTH) && !fl;
        do_pop  = rdy && (model.size() > 0) && !fl;
        @(posedge clk);
        if (fl) begin
            model.delete();
        end else begin
            if (do_pop)  void'(model.pop_front());
            if (do_push) model.push_back(p);
        end
        #1;
        checkAll(tag);
    endtask

    initial begin
        pair_t a;
        pair_t e;
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.in_instr_1 = '0;
        bus.in_instr_2 = '0;
        bus.in_pc_1    = '0;
        bus.in_pc_2    = '0;
        #12;
        rst_n = 1'b1;
        checkAll("reset");

        // Single push becomes visible after one edge
        a = '{instr_1: 32'h1111_0001, instr_2: 32'h2222_0002, pc_1: 32'h40, pc_2: 32'h44};
        applyStimulus(1, 0, 0, a, "push_a");

        // Fill up, then hold a fifth pair that must wait for a pop
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, randPair(), "fill");
        e = randPair();
        applyStimulus(1, 0, 0, e, "full_hold");
        applyStimulus(1, 0, 0, e, "full_hold2");
        applyStimulus(1, 1, 0, e, "full_pop");
        applyStimulus(1, 0, 0, e, "full_accept");

        // Flush while full with a valid input and ready output
        applyStimulus(1, 1, 1, randPair(), "flush_full");
        applyStimulus(0, 0, 0, randPair(), "after_flush");

        // Simultaneous push and pop at count 2
        applyStimulus(1, 0, 0, randPair(), "two_a");
        applyStimulus(1, 0, 0, randPair(), "two_b");
        applyStimulus(1, 1, 0, randPair(), "push_pop");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, randPair(), "drain");

        // Continuous stream of 10 pairs wraps the pointers
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, randPair(), "stream");
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, randPair(), "stream_drain");

        // Asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, randPair(), "pre_reset");
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model.delete();
        #1;
        checkAll("async_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        checkAll("reset_release");
        a = randPair();
        applyStimulus(1, 0, 0, a, "post_reset_push");
        applyStimulus(0, 1, 0, randPair(), "post_reset_pop");

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 31) == 0), randPair(), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
